// File: rtl/mux_n_to_1_scan_if.sv
// Board-I/O bundle for mux_n_to_1_scan: channel words, select/mode/hold controls and muxed result.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives the controls and the slave drives the results.
interface mux_n_to_1_scan_if #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] DATA_IN;
    logic [SEL_W-1:0]          SEL;
    logic                      MODE;
    logic                      HOLD;
    logic [WIDTH-1:0]          DATA_OUT;
    logic [SEL_W-1:0]          CH_OUT;
    logic                      CH_STEP;
    logic                      SEL_ERR;

    modport master (
        output DATA_IN, SEL, MODE, HOLD,
        input  DATA_OUT, CH_OUT, CH_STEP, SEL_ERR
    );

    modport slave (
        input  DATA_IN, SEL, MODE, HOLD,
        output DATA_OUT, CH_OUT, CH_STEP, SEL_ERR
    );
endinterface

// File: rtl/mux_n_to_1_scan.sv
// Registered CHANNELS:1 word mux: manual select from SEL, or auto-scan stepped by a SCAN_DIV prescaler.
// Latency: 1 cycle input-to-output; 3 cycles for SEL/MODE/HOLD when MUX_INPUT_SYNC_EN adds 2-flop syncs.
// Backpressure: none; HOLD freezes output, channel and prescaler (mode changes still tracked).
module mux_n_to_1_scan #(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int SCAN_DIV = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    mux_n_to_1_scan_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]    TC      = PW'(SCAN_DIV - 1);
    localparam logic [SEL_W:0]   NCH     = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    // SCAN_PEND: MODE went high while HOLD was set, so scan entry init is still owed.
    typedef enum logic [1:0] {
        ST_MANUAL    = 2'd0,
        ST_SCAN_PEND = 2'd1,
        ST_SCAN      = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [SEL_W-1:0] ch_q, ch_nxt;
    logic [PW-1:0]    presc_q, presc_nxt;
    logic [WIDTH-1:0] dout_q, dout_nxt, sel_word;
    logic             step_q, step_nxt;
    logic             err_q, err_nxt;
    logic             sel_bad;

    logic [SEL_W-1:0] sel_s;
    logic             mode_s;
    logic             hold_s;

`ifdef MUX_INPUT_SYNC_EN
    logic [SEL_W-1:0] sel_m;
    logic             mode_m;
    logic             hold_m;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_m  <= '0;
            mode_m <= 1'b0;
            hold_m <= 1'b0;
            sel_s  <= '0;
            mode_s <= 1'b0;
            hold_s <= 1'b0;
        end else begin
            sel_m  <= bus.SEL;
            mode_m <= bus.MODE;
            hold_m <= bus.HOLD;
            sel_s  <= sel_m;
            mode_s <= mode_m;
            hold_s <= hold_m;
        end
    end
`else
    assign sel_s  = bus.SEL;
    assign mode_s = bus.MODE;
    assign hold_s = bus.HOLD;
`endif

    assign sel_bad = ({1'b0, sel_s} >= NCH);

    always_comb begin
        state_nxt = state_q;
        ch_nxt    = ch_q;
        presc_nxt = presc_q;
        err_nxt   = err_q;
        dout_nxt  = dout_q;
        step_nxt  = 1'b0;
        sel_word  = '0;

        if (hold_s) begin
            if (!mode_s)
                state_nxt = ST_MANUAL;
            else if (state_q == ST_MANUAL)
                state_nxt = ST_SCAN_PEND;
        end else if (!mode_s) begin
            state_nxt = ST_MANUAL;
            ch_nxt    = sel_s;
            presc_nxt = '0;
            err_nxt   = sel_bad;
        end else if (state_q != ST_SCAN) begin
            state_nxt = ST_SCAN;
            ch_nxt    = sel_bad ? '0 : sel_s;
            presc_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            err_nxt = 1'b0;
            if (presc_q == TC) begin
                presc_nxt = '0;
                ch_nxt    = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
            end else begin
                presc_nxt = presc_q + PW'(1);
            end
        end

        // Out-of-range channel numbers fall through the loop and yield a zero word.
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_nxt == SEL_W'(i))
                sel_word = bus.DATA_IN[i*WIDTH +: WIDTH];
        end

        if (!hold_s) begin
            dout_nxt = sel_word;
            step_nxt = (ch_nxt != ch_q);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_MANUAL;
            ch_q    <= '0;
            presc_q <= '0;
            dout_q  <= '0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ch_q    <= ch_nxt;
            presc_q <= presc_nxt;
            dout_q  <= dout_nxt;
            step_q  <= step_nxt;
            err_q   <= err_nxt;
        end
    end

    assign bus.DATA_OUT = dout_q;
    assign bus.CH_OUT   = ch_q;
    assign bus.CH_STEP  = step_q;
    assign bus.SEL_ERR  = err_q;
endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Bench for mux_n_to_1_scan: directed literal sequences plus randomized traffic against a cycle model.
// Honours MUX_INPUT_SYNC_EN by delaying the model's view of SEL/MODE/HOLD by two cycles.
module tb_mux_n_to_1_scan;
    localparam int W  = 3;
    localparam int C  = 3;
    localparam int S  = 2;
    localparam int DV = 4;
    localparam int DW = C * W;
    localparam logic [DW-1:0] DIN = 9'b101_010_001;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   seqc[4] = '{2, 0, 1, 2};
    int   wd[3]   = '{1, 2, 5};

    mux_n_to_1_scan_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus ();

    mux_n_to_1_scan #(.WIDTH(W), .CHANNELS(C), .SEL_W(S), .SCAN_DIV(DV)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout"}, int'(bus.DATA_OUT), 0);
        chk({tag, "_ch"},   int'(bus.CH_OUT),   0);
        chk({tag, "_step"}, int'(bus.CH_STEP),  0);
        chk({tag, "_err"},  int'(bus.SEL_ERR),  0);
    endtask

    // Reference model: scan_ready says scan entry has been performed; cnt counts
    // cycles spent on the current channel and a step is due after DV of them.
    int m_ch = 0, m_cnt = 0, m_dout = 0, m_err = 0, m_step = 0;
    bit m_ready = 1'b0;
    int d1_sel = 0, d2_sel = 0, d1_mode = 0, d2_mode = 0, d1_hold = 0, d2_hold = 0;

    initial forever begin
        int e_sel, e_mode, e_hold, prev;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ch = 0; m_cnt = 0; m_dout = 0; m_err = 0; m_step = 0; m_ready = 1'b0;
            d1_sel = 0; d2_sel = 0; d1_mode = 0; d2_mode = 0; d1_hold = 0; d2_hold = 0;
        end else begin
`ifdef MUX_INPUT_SYNC_EN
            e_sel = d2_sel; e_mode = d2_mode; e_hold = d2_hold;
            d2_sel = d1_sel; d2_mode = d1_mode; d2_hold = d1_hold;
            d1_sel = int'(bus.SEL); d1_mode = int'(bus.MODE); d1_hold = int'(bus.HOLD);
`else
            e_sel = int'(bus.SEL); e_mode = int'(bus.MODE); e_hold = int'(bus.HOLD);
`endif
            prev = m_ch;
            if (e_hold != 0) begin
                m_step = 0;
                if (e_mode == 0) m_ready = 1'b0;
            end else begin
                if (e_mode == 0) begin
                    m_ready = 1'b0;
                    m_ch = e_sel; m_cnt = 0; m_err = (e_sel >= C) ? 1 : 0;
                end else if (!m_ready) begin
                    m_ready = 1'b1;
                    m_ch = (e_sel < C) ? e_sel : 0; m_cnt = 0; m_err = 0;
                end else begin
                    m_err = 0;
                    m_cnt++;
                    if (m_cnt == DV) begin
                        m_cnt = 0;
                        m_ch = (m_ch + 1) % C;
                    end
                end
                m_dout = (m_ch < C) ? int'((bus.DATA_IN >> (m_ch * W)) & DW'(7)) : 0;
                m_step = (m_ch != prev) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_dout", int'(bus.DATA_OUT), m_dout);
            chk("m_ch",   int'(bus.CH_OUT),   m_ch);
            chk("m_step", int'(bus.CH_STEP),  m_step);
            chk("m_err",  int'(bus.SEL_ERR),  m_err);
        end
    end

    initial begin
        int hold_burst;
        rst_n = 1'b1;
        bus.DATA_IN = '1; bus.SEL = 2'd2; bus.MODE = 1'b1; bus.HOLD = 1'b0;
        #1 rst_n = 1'b0;
        #2 chk_zero("rst_hold_a");
        repeat (3) @(negedge clk);
        chk_zero("rst_hold_b");
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(negedge clk);
        // Asynchronous assert mid-cycle while scanning with nonzero data.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero("rst_async");
        @(negedge clk);
        chk_zero("rst_low");
        bus.DATA_IN = DIN; bus.SEL = 2'd0; bus.MODE = 1'b0; bus.HOLD = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX_INPUT_SYNC_EN
        repeat (4) @(negedge clk);
        chk("sync_base_dout", int'(bus.DATA_OUT), 1);
        bus.SEL = 2'd1;
        @(negedge clk); chk("sync_lat1_dout", int'(bus.DATA_OUT), 1);
        @(negedge clk); chk("sync_lat2_dout", int'(bus.DATA_OUT), 1);
        @(negedge clk); chk("sync_lat3_dout", int'(bus.DATA_OUT), 2);
        chk("sync_lat3_step", int'(bus.CH_STEP), 1);
`else
        @(negedge clk);
        chk("man0_dout", int'(bus.DATA_OUT), 1);
        chk("man0_step", int'(bus.CH_STEP),  0);
        bus.SEL = 2'd1;
        @(negedge clk);
        chk("man1_dout", int'(bus.DATA_OUT), 2);
        chk("man1_ch",   int'(bus.CH_OUT),   1);
        chk("man1_step", int'(bus.CH_STEP),  1);
        @(negedge clk);
        chk("man1_step_end", int'(bus.CH_STEP), 0);
        bus.SEL = 2'd3;
        @(negedge clk);
        chk("bad_dout", int'(bus.DATA_OUT), 0);
        chk("bad_err",  int'(bus.SEL_ERR),  1);
        chk("bad_ch",   int'(bus.CH_OUT),   3);

        bus.SEL = 2'd2; bus.MODE = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("scan_ch",   int'(bus.CH_OUT),   seqc[i/4]);
            chk("scan_dout", int'(bus.DATA_OUT), wd[seqc[i/4]]);
            chk("scan_step", int'(bus.CH_STEP),  (i % 4 == 0) ? 1 : 0);
        end
        repeat (3) @(negedge clk);
        bus.HOLD = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ch",   int'(bus.CH_OUT),   2);
            chk("hold_dout", int'(bus.DATA_OUT), 5);
            chk("hold_step", int'(bus.CH_STEP),  0);
        end
        bus.HOLD = 1'b0;
        @(negedge clk);
        chk("unhold_ch",   int'(bus.CH_OUT),   0);
        chk("unhold_step", int'(bus.CH_STEP),  1);
        chk("unhold_dout", int'(bus.DATA_OUT), 1);
        @(negedge clk);
        chk("unhold_step_end", int'(bus.CH_STEP), 0);

        bus.MODE = 1'b0; bus.SEL = 2'd3;
        @(negedge clk);
        chk("exit_ch",  int'(bus.CH_OUT),  3);
        chk("exit_err", int'(bus.SEL_ERR), 1);
        bus.MODE = 1'b1;
        @(negedge clk);
        chk("entry_bad_ch",   int'(bus.CH_OUT),   0);
        chk("entry_bad_err",  int'(bus.SEL_ERR),  0);
        chk("entry_bad_dout", int'(bus.DATA_OUT), 1);
        bus.MODE = 1'b0;
        @(negedge clk);
        chk("reexit_err", int'(bus.SEL_ERR), 1);
        chk("reexit_ch",  int'(bus.CH_OUT),  3);
`endif

        hold_burst = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bus.SEL = S'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) bus.MODE = ~bus.MODE;
            if (hold_burst == 0 && $urandom_range(0, 79) == 0) hold_burst = $urandom_range(3, 12);
            if (hold_burst > 0) begin
                bus.HOLD = 1'b1;
                hold_burst--;
            end else begin
                bus.HOLD = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 2) == 0) bus.DATA_IN = DW'($urandom);
            if (i == 1500) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk_zero("rand_rst");
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
